// File: rtl/i2s_rx.sv
// I2S slave receiver. It synchronizes the external bclk, lrclk and data
// into clk, detects bclk rising edges and deserializes MSB-first,
// one-bit-delayed I2S words. Each complete left+right pair is presented
// with a single-cycle sample_valid strobe.
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_error
);

  // The counter is wide enough that a saturated count can never alias SLOT_WIDTH.
  localparam int MAXW = (SLOT_WIDTH > SAMPLE_WIDTH) ? SLOT_WIDTH : SAMPLE_WIDTH;
  localparam int CW   = $clog2(MAXW + 2);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW:0]   SLOT_LEN = (CW+1)'(SLOT_WIDTH);

  typedef enum logic [1:0] {SEEK, LEFT, RIGHT} state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrclk_sync_q, data_sync_q;
  logic                   prev_bclk_q;
  logic                   rise_q, ws_q, bit_q;

  state_e                  state_q, state_d;
  logic                    ws_prev_q, ws_prev_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] word_q, word_d, word_wr;
  logic [SAMPLE_WIDTH-1:0] left_stage_q, left_stage_d;
  logic                    left_ok_q, left_ok_d;
  logic [SAMPLE_WIDTH-1:0] sample_left_q, sample_left_d;
  logic [SAMPLE_WIDTH-1:0] sample_right_q, sample_right_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic                    len_ok, trans;

  // Synchronize all three inputs through the same depth so they stay aligned,
  // then register the rise strobe together with the ws/data sampled at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      data_sync_q  <= '0;
      prev_bclk_q  <= 1'b0;
      rise_q       <= 1'b0;
      ws_q         <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], i2s_data};
      prev_bclk_q  <= bclk_sync_q[SYNC_STAGES-1];
      rise_q       <= bclk_sync_q[SYNC_STAGES-1] & ~prev_bclk_q;
      ws_q         <= lrclk_sync_q[SYNC_STAGES-1];
      bit_q        <= data_sync_q[SYNC_STAGES-1];
    end
  end

  // Deserializer and SEEK/LEFT/RIGHT framing; ws tracking continues while
  // disabled so a re-enable resyncs on the next real channel change.
  always_comb begin
    state_d        = state_q;
    ws_prev_d      = ws_prev_q;
    bit_cnt_d      = bit_cnt_q;
    word_d         = word_q;
    left_stage_d   = left_stage_q;
    left_ok_d      = left_ok_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    valid_d        = 1'b0;
    error_d        = 1'b0;

    // Current word with this rise's bit placed; bits past the word are dropped.
    word_wr = word_q;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (bit_cnt_q == CW'(SAMPLE_WIDTH - 1 - i)) word_wr[i] = bit_q;
    end

    // The transition bit is the old word's LSB, so its length is count+1.
    len_ok = (({1'b0, bit_cnt_q} + (CW+1)'(1)) == SLOT_LEN);
    trans  = rise_q && (ws_q != ws_prev_q);

    if (rise_q) begin
      ws_prev_d = ws_q;
      if (trans) begin
        word_d    = '0;
        bit_cnt_d = '0;
      end else begin
        word_d = word_wr;
        if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end

    if (!enable) begin
      state_d   = SEEK;
      left_ok_d = 1'b0;
    end else if (trans) begin
      case (state_q)
        SEEK: state_d = ws_q ? RIGHT : LEFT;
        LEFT: begin
          if (ws_q) begin
            if (len_ok) begin
              left_stage_d = word_wr;
              left_ok_d    = 1'b1;
            end else begin
              error_d   = 1'b1;
              left_ok_d = 1'b0;
            end
            state_d = RIGHT;
          end
        end
        RIGHT: begin
          if (!ws_q) begin
            if (len_ok && left_ok_q) begin
              sample_left_d  = left_stage_q;
              sample_right_d = word_wr;
              valid_d        = 1'b1;
            end
            if (!len_ok) error_d = 1'b1;
            left_ok_d = 1'b0;
            state_d   = LEFT;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  // Framing state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SEEK;
      ws_prev_q      <= 1'b0;
      bit_cnt_q      <= '0;
      word_q         <= '0;
      left_stage_q   <= '0;
      left_ok_q      <= 1'b0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      valid_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ws_prev_q      <= ws_prev_d;
      bit_cnt_q      <= bit_cnt_d;
      word_q         <= word_d;
      left_stage_q   <= left_stage_d;
      left_ok_q      <= left_ok_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      valid_q        <= valid_d;
      error_q        <= error_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = valid_q;
  assign frame_error  = error_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: directed I2S frames, a word-level model of the framing
// rules that schedules expected pulses, a per-cycle compare, and a few
// hand-computed literal expectations.
module tb_i2s_rx;
  localparam int HALF = 8;  // bclk half period in clk cycles -> 16 clk/bclk

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        bclk = 1'b0, lrclk = 1'b0, data = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, frame_error;

  i2s_rx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(data),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int vcyc[$];
  int err_seen = 0;

  typedef struct {
    int          cyc;
    bit          rst;
    bit          v;
    bit          e;
    logic [15:0] l;
    logic [15:0] r;
  } ev_t;
  ev_t evq[$];

  typedef enum {M_SEEK, M_LEFT, M_RIGHT} mst_e;
  mst_e        m_st = M_SEEK;
  bit          m_ws_prev = 1'b0, m_left_ok = 1'b0, m_en = 1'b0;
  logic [15:0] m_stage = '0;
  bit          m_bits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Word-level model: collect bits of a channel word; on a ws change the
  // new bit closes the old word. Pulses appear 3 clk after the edge that
  // first sees bclk high (two sync flops plus the rise register).
  task automatic model_rise(input bit ws, input bit b, input int n_edge);
    ev_t ev;
    int len;
    logic [15:0] w;
    if (ws != m_ws_prev) begin
      m_bits.push_back(b);
      len = m_bits.size();
      w = '0;
      for (int i = 0; i < len && i < 16; i++) w[15-i] = m_bits[i];
      m_bits.delete();
      if (m_en) begin
        ev.cyc = n_edge + 3; ev.rst = 0; ev.v = 0; ev.e = 0; ev.l = '0; ev.r = '0;
        case (m_st)
          M_SEEK: m_st = ws ? M_RIGHT : M_LEFT;
          M_LEFT: begin
            if (len == 16) begin m_stage = w; m_left_ok = 1; end
            else begin ev.e = 1; m_left_ok = 0; end
            m_st = M_RIGHT;
          end
          default: begin
            if (len == 16 && m_left_ok) begin ev.v = 1; ev.l = m_stage; ev.r = w; end
            if (len != 16) ev.e = 1;
            m_left_ok = 0;
            m_st = M_LEFT;
          end
        endcase
        if (ev.v || ev.e) evq.push_back(ev);
      end
    end else begin
      m_bits.push_back(b);
    end
    m_ws_prev = ws;
  endtask

  task automatic model_reset();
    ev_t ev;
    m_st = M_SEEK; m_ws_prev = 0; m_left_ok = 0; m_bits.delete();
    ev.cyc = cyc + 1; ev.rst = 1; ev.v = 0; ev.e = 0; ev.l = '0; ev.r = '0;
    evq.push_back(ev);
  endtask

  task automatic set_en(input bit v);
    enable = v;
    m_en = v;
    if (!v) begin m_st = M_SEEK; m_left_ok = 0; end
  endtask

  // One bclk period starting at a negedge; optional 3-clk reset in the low phase.
  task automatic bit_period(input bit ws, input bit b, input bit do_rst);
    bclk = 0; lrclk = ws; data = b;
    if (do_rst) begin
      reset_n = 0;
      model_reset();
      #1;
      chk("rst_now_left", sample_left, 0);
      chk("rst_now_right", sample_right, 0);
      chk("rst_now_valid", sample_valid, 0);
      chk("rst_now_err", frame_error, 0);
      repeat (3) @(negedge clk);
      reset_n = 1;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    bclk = 1;
    model_rise(ws, b, cyc + 1);
    repeat (HALF) @(negedge clk);
  endtask

  // Bits [from,to) of an n-bit channel word; the last bit carries the next ws.
  task automatic send_word(input bit ws, input logic [15:0] v, input int n,
                           input int from, input int to, input int rst_at);
    bit b, w;
    for (int j = from; j < to; j++) begin
      b = (j < 16) ? v[15-j] : 1'b0;
      w = (j == n - 1) ? ~ws : ws;
      bit_period(w, b, j == rst_at);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl);
    send_word(0, l, nl, 0, nl, -1);
    send_word(1, r, 16, 0, 16, -1);
  endtask

  initial begin
    int v0, e0;
    ev_t ev;
    bit ev_v, ev_e;
    logic [15:0] exl, exr;
    exl = '0; exr = '0;

    // Per-cycle compare against the model's schedule.
    fork
      forever begin
        @(posedge clk);
        cyc++;
        #1;
        ev_v = 0; ev_e = 0;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
          ev = evq.pop_front();
          if (ev.rst) begin
            exl = '0; exr = '0;
          end else begin
            if (ev.cyc == cyc) begin ev_v = ev.v; ev_e = ev.e; end
            if (ev.v) begin exl = ev.l; exr = ev.r; end
          end
        end
        chk("cyc_valid", sample_valid, ev_v);
        chk("cyc_error", frame_error, ev_e);
        chk("cyc_left", sample_left, exl);
        chk("cyc_right", sample_right, exr);
        if (sample_valid === 1'b1) vcyc.push_back(cyc);
        if (frame_error === 1'b1) err_seen++;
      end
    join_none

    reset_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_left", sample_left, 0);
    chk("reset_right", sample_right, 0);
    chk("reset_valid", sample_valid, 0);
    reset_n = 1;
    set_en(1);
    @(negedge clk);

    // Nominal stream: first frame only finds sync, then one valid per 512 clk.
    send_frame(16'h1234, 16'hABCD, 16);
    chk("nom_first_none", vcyc.size(), 0);
    repeat (4) send_frame(16'h1234, 16'hABCD, 16);
    chk("nom_count", vcyc.size(), 4);
    for (int i = 0; i + 1 < vcyc.size(); i++) chk("nom_period", vcyc[i+1] - vcyc[i], 512);
    chk("nom_left", sample_left, 16'h1234);
    chk("nom_right", sample_right, 16'hABCD);
    chk("nom_no_err", err_seen, 0);

    // Boundary values.
    send_frame(16'h8000, 16'h7FFF, 16);
    chk("bnd1_left", sample_left, 16'h8000);
    chk("bnd1_right", sample_right, 16'h7FFF);
    send_frame(16'hFFFF, 16'h0000, 16);
    chk("bnd2_left", sample_left, 16'hFFFF);
    chk("bnd2_right", sample_right, 16'h0000);
    chk("bnd_period", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2], 512);

    // Short left slot: one error, no valid, outputs hold; next frame recovers.
    v0 = vcyc.size(); e0 = err_seen;
    send_frame(16'h1234, 16'h5555, 15);
    chk("slot_err_count", err_seen - e0, 1);
    chk("slot_no_valid", vcyc.size() - v0, 0);
    chk("slot_hold_left", sample_left, 16'hFFFF);
    chk("slot_hold_right", sample_right, 16'h0000);
    send_frame(16'h1234, 16'hABCD, 16);
    chk("slot_recover", vcyc.size() - v0, 1);
    chk("slot_rec_left", sample_left, 16'h1234);

    // Enable low for one frame, released mid right slot.
    v0 = vcyc.size(); e0 = err_seen;
    send_word(0, 16'h1111, 16, 0, 16, -1);
    send_word(1, 16'h2222, 16, 0, 8, -1);
    set_en(0);
    send_word(1, 16'h2222, 16, 8, 16, -1);
    send_word(0, 16'h3333, 16, 0, 16, -1);
    send_word(1, 16'h4444, 16, 0, 8, -1);
    chk("en_low_no_valid", vcyc.size() - v0, 0);
    chk("en_low_hold_left", sample_left, 16'h1234);
    chk("en_low_hold_right", sample_right, 16'hABCD);
    set_en(1);
    send_word(1, 16'h4444, 16, 8, 16, -1);
    chk("en_mid_right_none", vcyc.size() - v0, 0);
    send_frame(16'h5555, 16'h6666, 16);
    chk("en_resume", vcyc.size() - v0, 1);
    chk("en_resume_left", sample_left, 16'h5555);
    chk("en_resume_right", sample_right, 16'h6666);
    chk("en_no_err", err_seen - e0, 0);

    // Reset mid right slot: outputs clear, resync via SEEK->RIGHT whose
    // truncated word raises an error, then a full pair is required.
    v0 = vcyc.size(); e0 = err_seen;
    send_word(0, 16'h0F0F, 16, 0, 16, -1);
    send_word(1, 16'hF0F0, 16, 0, 16, 6);
    chk("rst_no_valid", vcyc.size() - v0, 0);
    chk("rst_short_err", err_seen - e0, 1);
    chk("rst_left_zero", sample_left, 0);
    send_frame(16'h0F0F, 16'hF0F0, 16);
    chk("rst_resume", vcyc.size() - v0, 1);
    chk("rst_res_left", sample_left, 16'h0F0F);
    chk("rst_res_right", sample_right, 16'hF0F0);

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
